// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, fetches words (in-order rsp), buffers {pc, word}; response visible 1 cycle later, held until inst_ready.
// Request credit caps in-flight + buffered at FIFO_DEPTH. `FETCH_MISALIGN_CHECK_EN traps misaligned redirect targets.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        misalign_fault
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {IDLE, RUN, HALTED, FAULT} state_e;
`else
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_e;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] in_flight_q, in_flight_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  entry_t        mem_q [FIFO_DEPTH];
  entry_t        push_dat;
  logic          req_fire, push, pop;
  logic [CW:0]   occupancy;
  logic [31:0]   target_pc;

  assign target_pc = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  logic bad_target;
  assign bad_target     = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign misalign_d     = misalign_q | bad_target;
  assign misalign_fault = misalign_q;
`else
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign misalign_fault      = 1'b0;
`endif

  assign inst_valid = (state_q == RUN) && (count_q != '0);
  assign inst_pc    = mem_q[rd_ptr_q].pc;
  assign inst_data  = mem_q[rd_ptr_q].data;
  assign pop        = inst_valid && inst_ready && !redirect_valid;
  assign push       = imem_rsp_valid && !redirect_valid && (discard_q == '0);
  assign push_dat   = '{pc: rsp_pc_q, data: imem_rsp_data};

  // A slot freed by this cycle's pop can be re-requested now: its response lands next cycle at the earliest.
  assign occupancy      = {1'b0, in_flight_q} + {1'b0, count_q} - (CW+1)'(pop);
  assign imem_req_valid = (state_q == RUN) && !redirect_valid && (occupancy < DEPTH_C);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (halt) state_d = HALTED;
      HALTED:  if (!halt) state_d = RUN;
      default: state_d = state_q;
    endcase
`ifdef FETCH_MISALIGN_CHECK_EN
    if (bad_target) state_d = FAULT;
`endif
  end

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    rsp_pc_d    = rsp_pc_q;
    in_flight_d = in_flight_q + CW'(req_fire) - CW'(imem_rsp_valid);
    discard_d   = discard_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (redirect_valid) begin
      // Everything still outstanding is stale, except a response that is already being dropped now.
      fetch_pc_d = target_pc;
      rsp_pc_d   = target_pc;
      discard_d  = in_flight_q - CW'(imem_rsp_valid);
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (imem_rsp_valid && (discard_q != '0)) discard_d = discard_q - CW'(1);
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      rsp_pc_q    <= RESET_PC;
      in_flight_q <= '0;
      discard_q   <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      rsp_pc_q    <= rsp_pc_d;
      in_flight_q <= in_flight_d;
      discard_q   <= discard_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      if (push) mem_q[wr_ptr_q] <= push_dat;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q  <= misalign_d;
`endif
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: random memory latency/ready, decode ready, redirects and halts;
// the expected {pc, word} stream lives in a scoreboard queue drained by an independent monitor.
module tb_instruction_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        misalign_fault;

  instruction_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .misalign_fault(misalign_fault)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;

  exp_t        exp_q[$];
  pend_t       pend_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          acc_count = 0;
  int          lat = 1;
  int          sb_pops = 0;
  bit          ready_always = 1'b1;
  logic [31:0] last_pc = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_F00D;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected stream after reset/redirect: sequential word addresses, wrapping at 2^32.
  task automatic sb_restart(input logic [31:0] pc);
    logic [31:0] p;
    p = {pc[31:2], 2'b00};
    exp_q.delete();
    for (int i = 0; i < 512; i++) begin
      exp_q.push_back('{pc: p, data: mem_word(p)});
      p = p + 32'd4;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    redirect_valid = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    sb_restart(pc);
  endtask

  task automatic wait_inst(input string name, input logic [31:0] exp_pc);
    int n;
    n = 0;
    tick(); #2;
    while (!inst_valid && n < 50) begin
      tick(); #2;
      n++;
    end
    if (!inst_valid) begin
      total++; bad++;
      $display("FAIL %s: inst_valid timeout, got 0 expected 1", name);
    end else check(name, inst_pc, exp_pc);
  endtask

  // Memory model: in-order responses, each at least lat cycles after acceptance.
  initial begin
    int          due;
    int          last_due;
    bit          stall_prev;
    logic [31:0] stall_addr;
    last_due = 0; stall_prev = 1'b0; stall_addr = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      imem_req_ready = ready_always ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_q[0].addr);
        void'(pend_q.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
      #3;
      if (rst_n && imem_req_valid) begin
        check("req_addr_align", {30'b0, imem_req_addr[1:0]}, 32'd0);
        if (stall_prev) check("req_addr_stable", imem_req_addr, stall_addr);
        if (imem_req_ready) begin
          due = cyc + lat;
          if (due <= last_due) due = last_due + 1;
          pend_q.push_back('{addr: imem_req_addr, due: due});
          last_due = due;
          acc_count++;
        end
        stall_prev = !imem_req_ready;
        stall_addr = imem_req_addr;
      end else stall_prev = 1'b0;
    end
  end

  // Monitor: every accepted instruction must be the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && inst_valid && inst_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL inst_unexpected: got pc %h expected no instruction", inst_pc);
        end else begin
          e = exp_q.pop_front();
          check("inst_pc", inst_pc, e.pc);
          check("inst_data", inst_data, e.data);
          last_pc = inst_pc;
          sb_pops++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          a0;
    int          n;
    bit          found;
    logic [31:0] pc_before;
    logic [31:0] r;
    rst_n = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
    sb_restart(RST_PC);
    repeat (3) @(negedge clk);
    #3;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, RST_PC);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst_data", inst_data, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_misalign", 32'(misalign_fault), 32'd0);

    // Back-to-back stream from RESET_PC, first instruction three cycles after reset release.
    tick(); rst_n = 1'b1; inst_ready = 1'b1;
    tick(); #2;
    check("c1_inst_valid", 32'(inst_valid), 32'd0);
    check("c1_req_valid", 32'(imem_req_valid), 32'd1);
    check("c1_req_addr", imem_req_addr, RST_PC);
    tick(); #2;
    check("c2_inst_valid", 32'(inst_valid), 32'd0);
    tick(); #2;
    check("c3_inst_valid", 32'(inst_valid), 32'd1);
    check("c3_inst_pc", inst_pc, 32'h100);
    tick(); #2;
    check("c4_inst_pc", inst_pc, 32'h104);
    tick(); #2;
    check("c5_inst_pc", inst_pc, 32'h108);

    // Decode stalled: only FIFO_DEPTH requests may go out.
    tick(); inst_ready = 1'b0; do_redirect(32'h300);
    a0 = acc_count;
    repeat (10) tick();
    #2;
    check("stall_req_valid", 32'(imem_req_valid), 32'd0);
    check("stall_req_count", 32'(acc_count - a0), 32'(DEPTH));
    tick(); inst_ready = 1'b1;
    repeat (8) tick();

    // Address wrap at the top of the space.
    tick(); do_redirect(32'hFFFF_FFF8);
    repeat (10) tick();

    // Redirect with stale words in flight under 3-cycle latency.
    lat = 3;
    repeat (8) tick();
    tick(); do_redirect(32'h200);
    wait_inst("redir_lat3_pc", 32'h200);
    repeat (10) tick();

    // Redirect colliding with a response and a decode handshake.
    lat = 1;
    repeat (6) tick();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (imem_rsp_valid && inst_valid && inst_ready) begin
        do_redirect(32'h400);
        found = 1'b1;
      end
    end
    if (!found) begin
      total++; bad++;
      $display("FAIL collide_setup: got no collision cycle expected one");
    end
    wait_inst("redir_collide_pc", 32'h400);
    repeat (6) tick();

    // Halt mid-stream, then resume at the next sequential pc.
    tick(); halt = 1'b1;
    tick(); a0 = acc_count;
    repeat (6) begin
      #2;
      check("halt_req_valid", 32'(imem_req_valid), 32'd0);
      check("halt_inst_valid", 32'(inst_valid), 32'd0);
      tick();
    end
    check("halt_no_new_req", 32'(acc_count - a0), 32'd0);
    pc_before = last_pc;
    halt = 1'b0;
    n = 0; found = 1'b0;
    while (!found && n < 20) begin
      tick(); #2;
      if (inst_valid) found = 1'b1;
      n++;
    end
    if (!found) begin
      total++; bad++;
      $display("FAIL halt_resume: inst_valid timeout, got 0 expected 1");
    end else check("halt_resume_pc", inst_pc, pc_before + 32'd4);
    repeat (6) tick();

    // Randomized traffic.
    ready_always = 1'b0;
    for (int c = 0; c < 1200; c++) begin
      tick();
      inst_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) lat = $urandom_range(1, 3);
      if (halt) begin
        if ($urandom_range(0, 7) == 0) halt = 1'b0;
      end else if ($urandom_range(0, 59) == 0) halt = 1'b1;
      if ($urandom_range(0, 24) == 0) begin
        r = $urandom;
        do_redirect({r[31:2], 2'b00});
      end
    end
    tick(); halt = 1'b0; inst_ready = 1'b1; ready_always = 1'b1; lat = 1;
    repeat (20) tick();
    check("sb_progress", 32'(sb_pops > 200), 32'd1);

    // Misaligned redirect target.
    tick(); do_redirect(32'h202);
`ifdef FETCH_MISALIGN_CHECK_EN
    exp_q.delete();
    tick(); #2;
    check("misalign_fault", 32'(misalign_fault), 32'd1);
    repeat (8) begin
      check("fault_req_valid", 32'(imem_req_valid), 32'd0);
      check("fault_inst_valid", 32'(inst_valid), 32'd0);
      tick(); #2;
    end
    check("misalign_sticky", 32'(misalign_fault), 32'd1);
`else
    wait_inst("misalign_ignored_pc", 32'h200);
    check("misalign_tied", 32'(misalign_fault), 32'd0);
    repeat (6) tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
